systolic_array_nxn: RTL and testbench
=====================================

// Module: systolic_array_nxn
// PURPOSE
//  Parametrised NxN weight-stationary systolic array; successor to the fixed 2x2 array in the TPU datapath.
//  Signed fixed-point MACs. Weights live in double-buffered (shadow/active) registers. Activations enter
//  from the west, partial sums flow south. Results and per-column valid leave the bottom row.
//  Column enable mask follows the unified-buffer column size.
// PARAMETERS
//  N        4   rows = columns of PEs (>=2)
//  DATA_W   16  activation/weight/psum width, signed two's complement
//  FRAC_W   8   fractional bits (Q(DATA_W-FRAC_W).FRAC_W)
// PORTS
//  clk                  in   1             rising-edge clock
//  rst                  in   1             async, active-high reset
//  sys_data_in          in   N*DATA_W      row r activation at [r*DATA_W +: DATA_W]; caller skews row r by r cycles
//  sys_valid_in         in   N             per-row activation valid (west edge)
//  sys_weight_in        in   N*DATA_W      column c weight at [c*DATA_W +: DATA_W] (north edge)
//  sys_accept_w         in   N             per-column shadow-weight shift enable
//  sys_switch_in        in   1             shadow->active copy pulse, enters PE(0,0)
//  ub_rd_col_size_in    in   $clog2(N+1)   number of active columns
//  ub_rd_col_size_valid_in in 1            load column-enable mask
//  sys_data_out         out  N*DATA_W      bottom-row psum, column c at [c*DATA_W +: DATA_W]
//  sys_valid_out        out  N             bottom-row valid per column
// BEHAVIOUR
//  - Reset: all PE regs (input, valid, psum, shadow, active, switch), col mask = 0; sys_data_out = 0, sys_valid_out = 0.
//  - Col mask: on ub_rd_col_size_valid_in, mask <= (1<<min(size,N))-1; size 0 disables all; size>N clamps to N.
//  - Weight load: while sys_accept_w[c]: shadow(0,c) <= sys_weight_in[c], shadow(r,c) <= shadow(r-1,c).
//    N accept cycles fill a column; the first word presented ends in row N-1.
//  - Switch: registered chain PE(0,0) -> down col 0 -> east along each row. PE(r,c) sees the pulse r+c cycles after
//    sys_switch_in and does active <= shadow. Accept and switch in the same cycle: active takes the pre-shift shadow.
//  - PE(r,c), column enabled, every cycle:
//    input_out <= input_in, valid_out <= valid_in (east);
//    if valid_in: psum_out <= psum_in + trunc((input_in*active) >>> FRAC_W), else psum_out <= 0.
//    Row-0 psum_in = 0. Product is 2*DATA_W signed, arithmetic-shifted by FRAC_W, then narrowed to DATA_W.
//  - Column disabled: input_out/valid_out/psum_out forced to 0 each cycle; shadow/active weights retained,
//    accept/switch still honoured.
//  - Latency: a skewed vector whose row-0 element enters at cycle t appears on sys_data_out[c] with
//    sys_valid_out[c]=1 at cycle t+N+c. Throughput is one vector per cycle.
//  - Arithmetic default: two's-complement wrap on product narrowing and on add.
//  - Reset mid-operation: in-flight data discarded; outputs 0 from reset assertion; weights must be reloaded.
// CONFIGURATION
//  SYSTOLIC_SAT_EN defined: product narrowing and psum add saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  SYSTOLIC_SAT_EN undefined: wrap-around, no extra logic.
// TESTING (N=4, DATA_W=16, FRAC_W=8)
//  1. Reset: rst=1 mid-run -> sys_data_out=0, sys_valid_out=0 same cycle; post-reset computes yield 0 until reload.
//  2. Identity: size=4, load I (diag 0x0100), switch, stream x=[0x0100,0x0200,0x0080,0xFF00] skewed ->
//     out[c]=x[c] with valid at t+4+c.
//  3. Col mask: size=2, same stream -> cols 0,1 correct; sys_data_out[2],[3]=0 and sys_valid_out[3:2]=0 throughout.
//  4. Double buffer: compute with W1=I while shifting W2=2*I (0x0200) into shadow, switch at t0 -> vectors
//     entering before t0 give x, after t0 give 2x; no mixed column.
//  5. Overflow: all x=0x7F00, W col0 all 0x0200 -> wrapped sum without macro; 0x7FFF with SYSTOLIC_SAT_EN.
//  6. Negative: x=0xFF00 (-1.0), w=0x0180 (1.5) single row -> out=0xFE80 (-1.5).

Source files
------------

// File: rtl/systolic_array_nxn.sv
// systolic_array_nxn
//   NxN weight-stationary systolic array of signed fixed-point MACs
//   (Q(DATA_W-FRAC_W).FRAC_W).
//   - Activations enter from the west and move east.
//   - Partial sums move south.
//   - Bottom-row psums and valids leave as sys_data_out / sys_valid_out.
//   - Weights are double-buffered in every PE:
//       shadow: shifted in from the north edge.
//       active: used by the MAC, loaded from shadow by the switch wave.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   sys_data_in/valid_in     west-edge activations (row r at [r*DATA_W +: DATA_W]);
//                            the caller skews row r by r cycles
//   sys_weight_in/accept_w   north-edge shadow-weight shift, one enable per column
//   sys_switch_in            shadow->active pulse, enters PE(0,0)
//   ub_rd_col_size_in/_valid number of enabled columns (clamped to N)
//   sys_data_out/valid_out   bottom-row psum and valid per column
//
// Configuration
//   SYSTOLIC_SAT_EN  when defined, product narrowing and psum add saturate;
//                    otherwise both wrap (two's complement).
module systolic_array_nxn #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N*DATA_W-1:0]      sys_data_in,
  input  logic [N-1:0]             sys_valid_in,
  input  logic [N*DATA_W-1:0]      sys_weight_in,
  input  logic [N-1:0]             sys_accept_w,
  input  logic                     sys_switch_in,
  input  logic [$clog2(N+1)-1:0]   ub_rd_col_size_in,
  input  logic                     ub_rd_col_size_valid_in,
  output logic [N*DATA_W-1:0]      sys_data_out,
  output logic [N-1:0]             sys_valid_out
);
  localparam int PW = 2*DATA_W;

`ifdef SYSTOLIC_SAT_EN
  localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [PW-1:0]     PMAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0]     PMIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  logic [N-1:0] r_col_en, w_mask;

  // PE register outputs, exported so neighbours can read them
  logic signed [DATA_W-1:0] w_in     [N][N];
  logic signed [DATA_W-1:0] w_psum   [N][N];
  logic signed [DATA_W-1:0] w_shadow [N][N];
  logic                     w_vld    [N][N];
  logic                     w_sw     [N][N];

  // Columns 0..size-1 enabled; comparing against every c < N clamps size > N for free
  always_comb begin
    w_mask = '0;
    for (int c = 0; c < N; c++) w_mask[c] = (int'(ub_rd_col_size_in) > c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_col_en <= '0;
    else if (ub_rd_col_size_valid_in) r_col_en <= w_mask;
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic signed [DATA_W-1:0] w_x, w_pin, w_win, w_p, w_sum;
      logic                     w_v, w_swi;
      logic signed [PW-1:0]     w_prod;
      logic signed [DATA_W-1:0] r_in, r_psum, r_shadow, r_active;
      logic                     r_vld, r_sw;
      logic                     w_unused_prod;

      if (c == 0) begin : g_west
        assign w_x = sys_data_in[r*DATA_W +: DATA_W];
        assign w_v = sys_valid_in[r];
      end else begin : g_east
        assign w_x = w_in[r][c-1];
        assign w_v = w_vld[r][c-1];
      end

      if (r == 0) begin : g_north
        assign w_pin = '0;
        assign w_win = sys_weight_in[c*DATA_W +: DATA_W];
      end else begin : g_south
        assign w_pin = w_psum[r-1][c];
        assign w_win = w_shadow[r-1][c];
      end

      // Switch wave: down column 0, then east along each row, so PE(r,c) fires
      // r+c cycles after the pulse -- exactly in step with the skewed data.
      if (r == 0 && c == 0) begin : g_sw_src
        assign w_swi = sys_switch_in;
      end else if (c == 0) begin : g_sw_col
        assign w_swi = w_sw[r-1][0];
      end else begin : g_sw_row
        assign w_swi = w_sw[r][c-1];
      end

      assign w_prod        = PW'(w_x) * PW'(r_active);
      assign w_unused_prod = ^w_prod;

`ifdef SYSTOLIC_SAT_EN
      logic signed [PW-1:0] w_sh;
      logic        [DATA_W:0] w_s1;
      assign w_sh  = w_prod >>> FRAC_W;
      assign w_p   = (w_sh > PMAX) ? DMAX :
                     (w_sh < PMIN) ? DMIN : w_sh[DATA_W-1:0];
      assign w_s1  = {w_pin[DATA_W-1], w_pin} + {w_p[DATA_W-1], w_p};
      // Top two bits disagree -> add overflowed; the extra bit holds the true sign
      assign w_sum = (w_s1[DATA_W] != w_s1[DATA_W-1]) ?
                     (w_s1[DATA_W] ? DMIN : DMAX) : w_s1[DATA_W-1:0];
`else
      assign w_p   = w_prod[FRAC_W +: DATA_W];
      assign w_sum = w_pin + w_p;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_in     <= '0;
          r_vld    <= 1'b0;
          r_psum   <= '0;
          r_shadow <= '0;
          r_active <= '0;
          r_sw     <= 1'b0;
        end else begin
          r_sw <= w_swi;
          // Reads the pre-shift shadow when accept and switch coincide
          if (w_swi)           r_active <= r_shadow;
          if (sys_accept_w[c]) r_shadow <= w_win;
          if (r_col_en[c]) begin
            r_in   <= w_x;
            r_vld  <= w_v;
            r_psum <= w_v ? w_sum : '0;
          end else begin
            r_in   <= '0;
            r_vld  <= 1'b0;
            r_psum <= '0;
          end
        end
      end

      assign w_in[r][c]     = r_in;
      assign w_vld[r][c]    = r_vld;
      assign w_psum[r][c]   = r_psum;
      assign w_shadow[r][c] = r_shadow;
      assign w_sw[r][c]     = r_sw;
    end

    // East-edge activation and switch have no consumer
    logic w_unused_east;
    assign w_unused_east = w_sw[r][N-1] ^ (^w_in[r][N-1]);
  end

  for (genvar c = 0; c < N; c++) begin : g_out
    assign sys_data_out[c*DATA_W +: DATA_W] = w_psum[N-1][c];
    assign sys_valid_out[c]                 = w_vld[N-1][c];
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Scoreboard bench for systolic_array_nxn (N=4, DATA_W=16, FRAC_W=8).
// Stimulus pushes hand-computed {value, cycle} expectations per column;
// a negedge monitor pops and compares whenever a column shows valid.
module tb_systolic_array_nxn;
  localparam int N  = 4;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N*DW-1:0]   sys_data_in = '0;
  logic [N-1:0]      sys_valid_in = '0;
  logic [N*DW-1:0]   sys_weight_in = '0;
  logic [N-1:0]      sys_accept_w = '0;
  logic              sys_switch_in = 1'b0;
  logic [2:0]        ub_rd_col_size_in = '0;
  logic              ub_rd_col_size_valid_in = 1'b0;
  logic [N*DW-1:0]   sys_data_out;
  logic [N-1:0]      sys_valid_out;

  systolic_array_nxn #(.N(N), .DATA_W(DW), .FRAC_W(8)) dut (
    .clk(clk), .rst(rst),
    .sys_data_in(sys_data_in), .sys_valid_in(sys_valid_in),
    .sys_weight_in(sys_weight_in), .sys_accept_w(sys_accept_w),
    .sys_switch_in(sys_switch_in),
    .ub_rd_col_size_in(ub_rd_col_size_in),
    .ub_rd_col_size_valid_in(ub_rd_col_size_valid_in),
    .sys_data_out(sys_data_out), .sys_valid_out(sys_valid_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] val; int cyc; } exp_t;
  exp_t sbq [N][$];

  int n_cmp = 0, n_bad = 0;
  int ncols_en = 0;            // hand-set number of columns expected enabled

  exp_t          mon_e;
  logic [DW-1:0] mon_got;

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      n_cmp++;
      if (sys_data_out !== '0 || sys_valid_out !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs: got data=%h valid=%b required 0/0 at cyc %0d",
                 sys_data_out, sys_valid_out, cyc);
      end
      for (int c = 0; c < N; c++) sbq[c].delete();
    end else begin
      for (int c = 0; c < N; c++) begin
        mon_got = sys_data_out[c*DW +: DW];
        if (sys_valid_out[c]) begin
          n_cmp++;
          if (sbq[c].size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_valid col%0d: got %h required no output at cyc %0d",
                     c, mon_got, cyc);
          end else begin
            mon_e = sbq[c].pop_front();
            if (mon_got !== mon_e.val || cyc != mon_e.cyc) begin
              n_bad++;
              $display("FAIL out col%0d: got %h at cyc %0d required %h at cyc %0d",
                       c, mon_got, cyc, mon_e.val, mon_e.cyc);
            end
          end
        end else if (sbq[c].size() > 0 && sbq[c][0].cyc < cyc) begin
          n_cmp++; n_bad++;
          mon_e = sbq[c].pop_front();
          $display("FAIL missing col%0d: got no valid required %h at cyc %0d",
                   c, mon_e.val, mon_e.cyc);
        end
        if (c >= ncols_en) begin
          n_cmp++;
          if (mon_got !== '0 || sys_valid_out[c] !== 1'b0) begin
            n_bad++;
            $display("FAIL col_disabled col%0d: got data=%h valid=%b required 0/0 at cyc %0d",
                     c, mon_got, sys_valid_out[c], cyc);
          end
        end
      end
    end
  end

  logic [DW-1:0] vx [8][N];    // vector v, row r
  logic [DW-1:0] ex [8][N];    // vector v, column c (hand-computed)
  logic [DW-1:0] wm [N][N];    // weight row r, column c

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_cols(input logic [2:0] size, input int n_en);
    step();
    ub_rd_col_size_in = size; ub_rd_col_size_valid_in = 1'b1;
    step();
    ub_rd_col_size_valid_in = 1'b0;
    ncols_en = n_en;
  endtask

  task automatic clear_w();
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) wm[r][c] = '0;
  endtask

  // Streams nv skewed vectors; optionally shifts wm in (k=0..N-1), pulses
  // switch at k==sw_k and asserts reset at k==rst_k (outputs before it expected).
  task automatic run(input int nv, input bit wload, input int sw_k, input int rst_k);
    int t0;
    int kmax;
    kmax = nv + 2*N + 4;
    for (int k = 0; k < kmax; k++) begin
      step();
      if (k == 0) begin
        t0 = cyc;
        for (int v = 0; v < nv; v++)
          for (int c = 0; c < ncols_en; c++)
            if (rst_k < 0 || v + N + c < rst_k)
              sbq[c].push_back('{ex[v][c], t0 + v + N + c});
      end
      for (int r = 0; r < N; r++) begin
        if (k - r >= 0 && k - r < nv) begin
          sys_data_in[r*DW +: DW] = vx[k-r][r];
          sys_valid_in[r] = 1'b1;
        end else begin
          sys_data_in[r*DW +: DW] = '0;
          sys_valid_in[r] = 1'b0;
        end
      end
      if (wload && k < N) begin
        for (int c = 0; c < N; c++) sys_weight_in[c*DW +: DW] = wm[N-1-k][c];
        sys_accept_w = '1;
      end else begin
        sys_weight_in = '0;
        sys_accept_w  = '0;
      end
      sys_switch_in = (k == sw_k);
      if (k == rst_k) begin
        rst = 1'b1;
        sys_data_in = '0; sys_valid_in = '0; sys_switch_in = 1'b0;
        step(); step();
        rst = 1'b0;
        ncols_en = 0;
        return;
      end
    end
    sys_switch_in = 1'b0;
  endtask

  task automatic set_vec(input int v, input logic [DW-1:0] x0, x1, x2, x3,
                         input logic [DW-1:0] e0, e1, e2, e3);
    vx[v][0] = x0; vx[v][1] = x1; vx[v][2] = x2; vx[v][3] = x3;
    ex[v][0] = e0; ex[v][1] = e1; ex[v][2] = e2; ex[v][3] = e3;
  endtask

  task automatic load_diag(input logic [DW-1:0] d);
    clear_w();
    for (int i = 0; i < N; i++) wm[i][i] = d;
    run(0, 1'b1, N, -1);
  endtask

  initial begin
    // Reset held: monitor checks zero outputs each negedge
    repeat (3) step();
    rst = 1'b0;

    // Identity
    set_cols(3'd4, 4);
    load_diag(16'h0100);
    set_vec(0, 16'h0100, 16'h0200, 16'h0080, 16'hFF00, 16'h0100, 16'h0200, 16'h0080, 16'hFF00);
    set_vec(1, 16'h0300, 16'hFE00, 16'h0040, 16'h0010, 16'h0300, 16'hFE00, 16'h0040, 16'h0010);
    run(2, 1'b0, -1, -1);

    // Reset mid-run: col0 emerges at t0+4, reset at t0+5 while col1 is on the output
    set_vec(0, 16'h0100, 16'h0200, 16'h0080, 16'hFF00, 16'h0100, 16'h0200, 16'h0080, 16'hFF00);
    run(1, 1'b0, -1, N + 1);

    // Post-reset, no reload: weights are cleared so every column yields 0
    set_cols(3'd4, 4);
    set_vec(0, 16'h0100, 16'h0200, 16'h0080, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run(1, 1'b0, -1, -1);

    // Reload identity, then column mask = 2
    load_diag(16'h0100);
    set_cols(3'd2, 2);
    set_vec(0, 16'h0100, 16'h0200, 16'h0080, 16'hFF00, 16'h0100, 16'h0200, 16'h0080, 16'hFF00);
    set_vec(1, 16'h0300, 16'hFE00, 16'h0040, 16'h0010, 16'h0300, 16'hFE00, 16'h0040, 16'h0010);
    run(2, 1'b0, -1, -1);

    // Size 0 disables everything
    set_cols(3'd0, 0);
    run(1, 1'b0, -1, -1);

    // Size 7 clamps to 4 columns
    set_cols(3'd7, 4);
    run(1, 1'b0, -1, -1);

    // Double buffer: shift 2I in while computing with I, switch at k=5
    clear_w();
    for (int i = 0; i < N; i++) wm[i][i] = 16'h0200;
    for (int v = 0; v < 8; v++) begin
      if (v <= 5)
        set_vec(v, 16'h0100, 16'h0200, 16'h0080, 16'hFF00, 16'h0100, 16'h0200, 16'h0080, 16'hFF00);
      else
        set_vec(v, 16'h0100, 16'h0200, 16'h0080, 16'hFF00, 16'h0200, 16'h0400, 16'h0100, 16'hFE00);
    end
    run(8, 1'b1, 5, -1);

    // Overflow: x=127.0 in every row, column 0 weights 2.0
    clear_w();
    for (int r = 0; r < N; r++) wm[r][0] = 16'h0200;
    run(0, 1'b1, N, -1);
`ifdef SYSTOLIC_SAT_EN
    set_vec(0, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
`else
    set_vec(0, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'hF800, 16'h0000, 16'h0000, 16'h0000);
`endif
    run(1, 1'b0, -1, -1);

    // Negative: -1.0*1.5 = -1.5; -1/256*0.5 floors to -1/256; both sum
    clear_w();
    wm[0][0] = 16'h0180;
    wm[1][0] = 16'h0080;
    run(0, 1'b1, N, -1);
    set_vec(0, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'hFE80, 16'h0000, 16'h0000, 16'h0000);
    set_vec(1, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    set_vec(2, 16'hFF00, 16'hFFFF, 16'h0000, 16'h0000, 16'hFE7F, 16'h0000, 16'h0000, 16'h0000);
    run(3, 1'b0, -1, -1);

    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
